// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: opcodes, FSM encoding, flag layout
// and the signed-overflow helpers used by the add/subtract datapath.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SHL = 4'b0101;
  localparam logic [3:0] OP_SHR = 4'b0110;
  localparam logic [3:0] OP_ADC = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_HOLD     = 2'd2
  } state_e;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_NEG   = 2;
  localparam int FLAG_OVF   = 3;
  localparam int NUM_FLAGS  = 4;

  // Overflow only from operand and result sign bits, so these stay width-agnostic.
  function automatic logic ovf_add(input logic sa, input logic sb, input logic sr);
    return (sa == sb) && (sr != sa);
  endfunction

  function automatic logic ovf_sub(input logic sa, input logic sb, input logic sr);
    return (sa != sb) && (sr != sa);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles.
// done/product are presented during the final iteration so the caller can register them.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] acc_nxt_s;
  logic [WIDTH-1:0]   mplier_r;
  logic [CW-1:0]      cnt_r;
  logic               busy_r;
  logic               done_s;

  // Accumulate the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    if (mplier_r[0]) begin
      acc_nxt_s = acc_r + mcand_r;
    end else begin
      acc_nxt_s = acc_r;
    end
  end

  assign done_s  = busy_r && (cnt_r == CW'(WIDTH - 1));
  assign done    = done_s;
  assign product = acc_nxt_s;

  // Operand load on start, then one shift-add step per cycle until the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_r  <= '0;
      acc_r    <= '0;
      mplier_r <= '0;
      cnt_r    <= '0;
      busy_r   <= 1'b0;
    end else if (start) begin
      mcand_r  <= {{WIDTH{1'b0}}, a};
      acc_r    <= '0;
      mplier_r <= b;
      cnt_r    <= '0;
      busy_r   <= 1'b1;
    end else if (busy_r) begin
      acc_r    <= acc_nxt_s;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      cnt_r    <= cnt_r + CW'(1);
      if (done_s) begin
        busy_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake, full flag set, carry-chained ADC and
// an iterative MUL; results are held while the consumer applies backpressure.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             neg,
  output logic             ovf,
  output logic             illegal
);

  state_e               state_r, state_nxt_s;
  logic                 in_ready_s, accept_s, is_mul_s, start_s, load_alu_s;
  logic                 mul_done_s;
  logic [2*WIDTH-1:0]   mul_prod_s;
  logic [WIDTH:0]       sum_s;
  logic [WIDTH-1:0]     res_s, wr_res_s;
  logic                 carry_s, ovf_s, illegal_s, wr_carry_s, wr_ovf_s, wr_ill_s;
  logic [NUM_FLAGS-1:0] wr_flags_s, flags_r;
  logic [WIDTH-1:0]     result_r;
  logic                 illegal_r, carry_q_r, out_valid_r;

  assign accept_s   = in_valid && in_ready_s;
  assign is_mul_s   = (op == OP_MUL);
  assign start_s    = accept_s && is_mul_s;
  assign load_alu_s = accept_s && !is_mul_s;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_s),
    .a       (a),
    .b       (b),
    .done    (mul_done_s),
    .product (mul_prod_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state; HOLD can chain straight into a new operation.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s)         state_nxt_s = ST_MUL_BUSY;
        else if (accept_s)   state_nxt_s = ST_HOLD;
        else                 state_nxt_s = ST_IDLE;
      end
      ST_MUL_BUSY: begin
        if (mul_done_s)      state_nxt_s = ST_HOLD;
        else                 state_nxt_s = ST_MUL_BUSY;
      end
      ST_HOLD: begin
        if (start_s)         state_nxt_s = ST_MUL_BUSY;
        else if (accept_s)   state_nxt_s = ST_HOLD;
        else if (out_ready)  state_nxt_s = ST_IDLE;
        else                 state_nxt_s = ST_HOLD;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: ready depends only on state and the consumer, never on in_valid.
  always_comb begin
    case (state_r)
      ST_IDLE: in_ready_s = 1'b1;
      ST_HOLD: in_ready_s = out_ready;
      default: in_ready_s = 1'b0;
    endcase
  end

  assign in_ready = in_ready_s;

  // Single-cycle datapath; SUB carry is the inverted borrow of A + ~B + 1.
  always_comb begin
    sum_s     = '0;
    res_s     = '0;
    carry_s   = 1'b0;
    ovf_s     = 1'b0;
    illegal_s = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        sum_s   = {1'b0, a} + {1'b0, b}
                + {{WIDTH{1'b0}}, (op == OP_ADC) ? carry_q_r : 1'b0};
        res_s   = sum_s[WIDTH-1:0];
        carry_s = sum_s[WIDTH];
        ovf_s   = ovf_add(a[WIDTH-1], b[WIDTH-1], res_s[WIDTH-1]);
      end
      OP_SUB: begin
        sum_s   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        res_s   = sum_s[WIDTH-1:0];
        carry_s = sum_s[WIDTH];
        ovf_s   = ovf_sub(a[WIDTH-1], b[WIDTH-1], res_s[WIDTH-1]);
      end
      OP_AND: res_s = a & b;
      OP_OR:  res_s = a | b;
      OP_XOR: res_s = a ^ b;
      OP_SHL: begin
        res_s   = {a[WIDTH-2:0], 1'b0};
        carry_s = a[WIDTH-1];
      end
      OP_SHR: begin
        res_s   = {1'b0, a[WIDTH-1:1]};
        carry_s = a[0];
      end
      OP_MUL: res_s = '0;
      default: illegal_s = 1'b1;
    endcase
  end

  // Select the write-back source and derive the flag vector from it.
  always_comb begin
    if (mul_done_s) begin
      wr_res_s   = mul_prod_s[WIDTH-1:0];
      wr_carry_s = |mul_prod_s[2*WIDTH-1:WIDTH];
      wr_ovf_s   = 1'b0;
      wr_ill_s   = 1'b0;
    end else begin
      wr_res_s   = res_s;
      wr_carry_s = carry_s;
      wr_ovf_s   = ovf_s;
      wr_ill_s   = illegal_s;
    end
    wr_flags_s             = '0;
    wr_flags_s[FLAG_ZERO]  = (wr_res_s == '0);
    wr_flags_s[FLAG_CARRY] = wr_carry_s;
    wr_flags_s[FLAG_NEG]   = wr_res_s[WIDTH-1];
    wr_flags_s[FLAG_OVF]   = wr_ovf_s;
  end

  // Result/flag registers; carry_q follows every legal result for ADC chaining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r    <= '0;
      flags_r     <= '0;
      illegal_r   <= 1'b0;
      carry_q_r   <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= (state_nxt_s == ST_HOLD);
      if (load_alu_s || mul_done_s) begin
        result_r  <= wr_res_s;
        flags_r   <= wr_flags_s;
        illegal_r <= wr_ill_s;
        if (!wr_ill_s) begin
          carry_q_r <= wr_carry_s;
        end
      end
    end
  end

  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign zero      = flags_r[FLAG_ZERO];
  assign carry     = flags_r[FLAG_CARRY];
  assign neg       = flags_r[FLAG_NEG];
  assign ovf       = flags_r[FLAG_OVF];
  assign illegal   = illegal_r;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: transaction-level reference model compared every
// cycle, directed cases with literal expectations, then randomized traffic.
module tb_alu_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   op = 4'd0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         zero, carry, neg, ovf, illegal;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carry(carry), .neg(neg), .ovf(ovf),
    .illegal(illegal)
  );

  typedef struct packed {
    logic [W-1:0] res;
    logic z, c, n, v, ill;
  } exp_t;

  // Reference arithmetic on plain integers.
  function automatic exp_t ref_op(input logic [3:0] o, input logic [W-1:0] x,
                                  input logic [W-1:0] y, input logic cin);
    exp_t   r;
    longint ux, uy, sx, sy, sd, span, full;
    span = longint'(1) << W;
    ux = longint'(x);
    uy = longint'(y);
    sx = x[W-1] ? ux - span : ux;
    sy = y[W-1] ? uy - span : uy;
    r = '0;
    sd = 0;
    case (o)
      4'd0: begin full = ux + uy; r.c = full >= span; sd = sx + sy; end
      4'd1: begin full = ux - uy; r.c = ux >= uy; sd = sx - sy; end
      4'd2: full = ux & uy;
      4'd3: full = ux | uy;
      4'd4: full = ux ^ uy;
      4'd5: begin full = ux * 2; r.c = x[W-1]; end
      4'd6: begin full = ux / 2; r.c = x[0]; end
      4'd7: begin full = ux + uy + longint'(cin); r.c = full >= span;
                  sd = sx + sy + longint'(cin); end
      4'd8: begin full = ux * uy; r.c = full >= span; end
      default: begin full = 0; r.ill = 1'b1; end
    endcase
    if (o <= 4'd1 || o == 4'd7) r.v = (sd >= span / 2) || (sd < -(span / 2));
    r.res = full[W-1:0];
    r.z = (r.res == '0);
    r.n = r.res[W-1];
    return r;
  endfunction

  exp_t m_out, m_pend, r_now;
  logic m_valid, m_carry, exp_ready;
  int   m_busy;

  assign exp_ready = (m_busy == 0) && (!m_valid || out_ready);
  always_comb r_now = ref_op(op, a, b, m_carry);

  // Transaction model: a pending result becomes visible after its latency.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_out <= '0; m_pend <= '0; m_carry <= 1'b0; m_busy <= 0;
    end else if (m_busy != 0) begin
      m_busy <= m_busy - 1;
      if (m_busy == 1) begin
        m_valid <= 1'b1; m_out <= m_pend; m_carry <= m_pend.c;
      end
    end else if (in_valid && exp_ready) begin
      if (op == 4'd8) begin
        m_busy <= W; m_pend <= r_now; m_valid <= 1'b0;
      end else begin
        m_valid <= 1'b1; m_out <= r_now;
        if (!r_now.ill) m_carry <= r_now.c;
      end
    end else if (out_ready) begin
      m_valid <= 1'b0;
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_in_ready", in_ready, exp_ready);
      chk("cyc_out_valid", out_valid, m_valid);
      chk("cyc_result", result, m_out.res);
      chk("cyc_zero", zero, m_out.z);
      chk("cyc_carry", carry, m_out.c);
      chk("cyc_neg", neg, m_out.n);
      chk("cyc_ovf", ovf, m_out.v);
      chk("cyc_illegal", illegal, m_out.ill);
    end
  end

  task automatic expect_out(input string nm, input logic [W-1:0] r, input logic z,
                            input logic c, input logic n, input logic v, input logic il);
    chk({nm, "_res"}, result, r);
    chk({nm, "_model_res"}, m_out.res, r);
    chk({nm, "_zero"}, zero, z);
    chk({nm, "_carry"}, carry, c);
    chk({nm, "_neg"}, neg, n);
    chk({nm, "_ovf"}, ovf, v);
    chk({nm, "_illegal"}, illegal, il);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int n;
    in_valid = 1'b1; op = o; a = x; b = y;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #3; n++;
    end
    chk("send_ready", in_ready, 1'b1);
    @(posedge clk); #2;
    in_valid = 1'b0; op = 4'($urandom); a = W'($urandom); b = W'($urandom);
  endtask

  task automatic do_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input int exp_lat);
    int lat;
    bit saw_ready;
    tick();
    send(o, x, y);
    lat = 0; saw_ready = 1'b0;
    @(negedge clk);
    while (!out_valid && lat < 64) begin
      if (in_ready) saw_ready = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, exp_lat);
    if (exp_lat > 0) chk("busy_in_ready", saw_ready, 1'b0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'hFFFF;
      3: return 16'h8000;
      4: return 16'h7FFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    expect_out("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    do_op(4'd7, 16'h0001, 16'h0002, 0);
    expect_out("adc_first", 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(4'd0, 16'hFFFF, 16'h0001, 0);
    expect_out("add_wrap", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // ADD then ADC on consecutive edges with in_valid held high.
    tick();
    in_valid = 1'b1; op = 4'd0; a = 16'hFFFF; b = 16'h0001;
    #1 chk("b2b_ready0", in_ready, 1'b1);
    tick();
    op = 4'd7; a = 16'h0001; b = 16'h0002;
    #1 chk("b2b_ready1", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    expect_out("b2b_adc", 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    do_op(4'd1, 16'h0003, 16'h0005, 0);
    expect_out("sub_neg", 16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    do_op(4'd1, 16'h8000, 16'h0001, 0);
    expect_out("sub_ovf", 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    do_op(4'd8, 16'h0100, 16'h0100, W);
    expect_out("mul_hi", 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    do_op(4'd8, 16'h0003, 16'h0007, W);
    expect_out("mul_small", 16'h0015, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_op(4'd5, 16'h8001, 16'h0000, 0);
    expect_out("shl", 16'h0002, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    do_op(4'd6, 16'h8001, 16'h0000, 0);
    expect_out("shr", 16'h4000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Backpressure: result must hold, then a new op is taken as the old one drains.
    tick();
    out_ready = 1'b0;
    send(4'd4, 16'h00FF, 16'h0F0F);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_result", result, 16'h0FF0);
      chk("bp_out_valid", out_valid, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
    end
    tick();
    out_ready = 1'b1; in_valid = 1'b1; op = 4'b1100; a = 16'h1234; b = 16'h5678;
    #1 chk("bp_release_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    expect_out("illegal", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset during a multiply aborts it and clears the ADC carry.
    do_op(4'd0, 16'hFFFF, 16'h0001, 0);
    tick();
    send(4'd8, 16'h0003, 16'h0007);
    repeat (4) tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    expect_out("rst_mid_mul", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    do_op(4'd7, 16'h0001, 16'h0001, 0);
    expect_out("adc_after_rst", 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic, checked every cycle by the compare process.
    for (int i = 0; i < 600; i++) begin
      tick();
      in_valid  = ($urandom_range(0, 9) < 7);
      op        = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15))
                                               : 4'($urandom_range(0, 8));
      a         = pick();
      b         = pick();
      out_ready = ($urandom_range(0, 9) < 7);
    end
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (W + 4) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the team's combinational 16-bit ALU. Accepts one operation at a time over a valid/ready handshake, registers RESULT plus a full flag set (ZERO, CARRY, NEG, OVF), adds carry-chained add (ADC) and an iterative multiply (MUL), and holds its result under output backpressure. It sits between the instruction sequencer and the register-file write-back path.

## Interface
- WIDTH, 16, operand/result width in bits (≥ 4)
- CLK  in  1  clock; all state updates on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- IN_VALID  in  1  operation request
- IN_READY  out  1  block can accept a request this cycle
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- OP  in  4  opcode
- OUT_VALID  out  1  RESULT/flags valid
- OUT_READY  in  1  consumer accepts result
- RESULT  out  WIDTH  registered result
- ZERO, CARRY, NEG, OVF  out  1 each  registered flags
- ILLEGAL  out  1  registered; result came from an undefined opcode

## Operation
- Opcodes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SHL by 1, 0110 SHR by 1 (logical), 0111 ADC (A+B+carry_q), 1000 MUL (low WIDTH bits of A*B); 1001–1111 illegal.
- carry_q: internal register, reloaded from CARRY each time a result is produced; reset 0. Not reloaded by illegal opcodes. ADC reads it at accept time.
- CARRY: ADD/ADC carry-out; SUB 1 = no borrow (A ≥ B unsigned); SHL A[WIDTH-1]; SHR A[0]; MUL 1 if upper WIDTH bits of product ≠ 0; logic ops 0.
- OVF: signed overflow for ADD/ADC/SUB; 0 otherwise.
- NEG = RESULT[WIDTH-1]; ZERO = (RESULT == 0).
- Illegal: RESULT 0, ZERO 1, other flags 0, ILLEGAL 1.
- A, B, OP captured on accept (IN_VALID & IN_READY); later changes are ignored.
- FSM: IDLE → (accept, non-MUL) → HOLD; IDLE → (accept MUL) → MUL_BUSY; MUL_BUSY → (WIDTH iterations done) → HOLD; HOLD → (OUT_READY) → IDLE, or directly to HOLD/MUL_BUSY when a new request is accepted in the same cycle.
- IN_READY = (state == IDLE) | (state == HOLD & OUT_READY). Combinational from state and OUT_READY only, never from IN_VALID.

## Timing
- Reset: state IDLE; RESULT 0; all flags 0; ILLEGAL 0; OUT_VALID 0; carry_q 0. IN_READY is 1 on the first cycle after deassertion.
- Single-cycle ops: accept on edge k → OUT_VALID/RESULT/flags valid after edge k.
- MUL: accept on edge k → OUT_VALID after edge k+WIDTH (one shift-add per cycle); IN_READY 0 throughout MUL_BUSY.
- RESULT, flags, and OUT_VALID hold stable while OUT_VALID & !OUT_READY.
- Back-to-back: with OUT_READY held 1 and IN_VALID held 1, single-cycle ops sustain one result per cycle. ADC in that stream uses the carry of the immediately preceding result.
- Reset mid-MUL aborts the operation with no output; carry_q clears.

## Structure
- Package alu_pkg: opcode localparams (OP_ADD … OP_MUL), FSM state encoding, flag bit-index constants.
- Sub-module alu_mul_iter: WIDTH-parametrised shift-add multiplier with start/done, 2·WIDTH accumulator, and iteration counter. The top level holds the FSM, single-cycle datapath, flag logic, and handshake.

## Test plan
- ADD 0xFFFF+0x0001 (WIDTH=16) → RESULT 0x0000, ZERO 1, CARRY 1, OVF 0, NEG 0, OUT_VALID one cycle after accept.
- ADD 0xFFFF+0x0001 then ADC 0x0001+0x0002 back-to-back → second RESULT 0x0004, CARRY 0; an ADC 0x0001+0x0002 issued first after reset → 0x0003.
- SUB 0x0003−0x0005 → 0xFFFE, CARRY 0, NEG 1; SUB 0x8000−0x0001 → 0x7FFF, OVF 1, CARRY 1.
- MUL 0x0100×0x0100 → RESULT 0x0000, ZERO 1, CARRY 1, 16 cycles after accept, IN_READY 0 meanwhile; MUL 0x0003×0x0007 → 0x0015, CARRY 0.
- OUT_READY held 0 for 5 cycles after an XOR 0x00FF^0x0F0F → RESULT 0x0FF0 stable, IN_READY 0; then OUT_READY 1 with IN_VALID 1 → new op accepted same cycle. OP 1100 → ILLEGAL 1, ZERO 1.
- RST_N pulsed low mid-MUL (cycle 5) → OUT_VALID 0, all outputs 0; next ADC 0x0001+0x0001 → 0x0002.
